// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a programmable table of layer configurations, driving the
// accelerator's config bus and start pulse, with watchdog and per-layer cycle count.
module layer_sequencer #(
  parameter int NUM_LAYERS = 8,
  parameter int LIDX_W     = 3,
  parameter int TMO_W      = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_addr,
  input  logic [36:0]       cfg_wdata,
  input  logic [LIDX_W:0]   num_layers,
  input  logic [TMO_W-1:0]  timeout_limit,
  input  logic              run,
  input  logic              abort,
  input  logic              acc_done,
  output logic              start,
  output logic [8:0]        ifm_size,
  output logic [10:0]       ifm_channel,
  output logic [1:0]        kernel_size,
  output logic [10:0]       num_filter,
  output logic              maxpool_mode,
  output logic [1:0]        maxpool_stride,
  output logic              upsample_mode,
  output logic [8:0]        ofm_size,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              busy,
  output logic              seq_done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [TMO_W-1:0]  last_cycles,
  output logic [2:0]        dbg_state
);

  // Handshake: run is a one-cycle request honoured only in IDLE; start is a one-cycle
  // pulse; acc_done is sampled only in WAIT, where abort takes priority over it.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_CFG   = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  state_t              state_q, state_d;
  logic [LIDX_W-1:0]   lidx_q, lidx_d;
  logic [LIDX_W:0]     nl_q, nl_d;
  logic [36:0]         cfg_q, cfg_d;
  logic [8:0]          ofm_q, ofm_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    last_q, last_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic [36:0]         tbl_q [NUM_LAYERS];

  logic [36:0]         entry;
  logic [8:0]          e_ifm;
  logic [10:0]         e_ch;
  logic [1:0]          e_k;
  logic [10:0]         e_nf;
  logic                e_mp;
  logic [1:0]          e_st;
  logic                e_up;
  logic [8:0]          conv_out;
  logic [8:0]          ofm_calc;
  logic                cfg_ok;
  logic                nl_ok;
  logic [LIDX_W:0]     lidx_inc;
  logic [TMO_W-1:0]    cnt_inc;
  logic                busy_w;

  assign entry = tbl_q[lidx_q];
  assign {e_ifm, e_ch, e_k, e_nf, e_mp, e_st, e_up} = entry;

  assign cfg_ok = ((e_k == 2'd1) || (e_k == 2'd3)) &&
                  (e_ifm >= {7'd0, e_k}) &&
                  (e_ch != 11'd0) &&
                  (e_nf != 11'd0) &&
                  !(e_mp && e_up) &&
                  (!e_mp || (e_st == 2'd1) || (e_st == 2'd2));

  // Output size keeps only 9 bits; an upsampled 511 wraps intentionally.
  assign conv_out = e_ifm - {7'd0, e_k} + 9'd1;
  always_comb begin
    ofm_calc = conv_out;
    if (e_up) begin
      ofm_calc = {conv_out[7:0], 1'b0};
    end else if (e_mp && (e_st == 2'd2)) begin
      ofm_calc = {1'b0, conv_out[8:1]};
    end
  end

  assign nl_ok    = (num_layers != '0) && (num_layers <= (LIDX_W+1)'(NUM_LAYERS));
  assign lidx_inc = {1'b0, lidx_q} + (LIDX_W+1)'(1);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + TMO_W'(1);
  assign busy_w   = (state_q == S_LOAD) || (state_q == S_START) ||
                    (state_q == S_WAIT) || (state_q == S_NEXT);

  always_comb begin
    state_d = state_q;
    lidx_d  = lidx_q;
    nl_d    = nl_q;
    cfg_d   = cfg_q;
    ofm_d   = ofm_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          err_d  = 1'b0;
          code_d = 2'd0;
          lidx_d = '0;
          if (nl_ok) begin
            nl_d    = num_layers;
            state_d = S_LOAD;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_CFG;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else begin
          cfg_d = entry;
          ofm_d = ofm_calc;
          if (cfg_ok) begin
            state_d = S_START;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = ERR_CFG;
          end
        end
      end
      S_START: begin
        cnt_d = '0;
        if (abort) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (abort) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else if (acc_done) begin
          last_d  = cnt_inc;
          state_d = S_NEXT;
        end else if ((timeout_limit != '0) && (cnt_inc == timeout_limit)) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          code_d  = ERR_ABORT;
        end else if (lidx_inc == nl_q) begin
          state_d = S_DONE;
        end else begin
          lidx_d  = lidx_inc[LIDX_W-1:0];
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      lidx_q  <= '0;
      nl_q    <= '0;
      cfg_q   <= '0;
      ofm_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lidx_q  <= lidx_d;
      nl_q    <= nl_d;
      cfg_q   <= cfg_d;
      ofm_q   <= ofm_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Table survives reset so a sequence can be replayed without reprogramming.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_w) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign {ifm_size, ifm_channel, kernel_size, num_filter,
          maxpool_mode, maxpool_stride, upsample_mode} = cfg_q;
  assign ofm_size    = ofm_q;
  assign layer_idx   = lidx_q;
  assign start       = (state_q == S_START);
  assign busy        = busy_w;
  assign seq_done    = (state_q == S_DONE);
  assign error       = err_q;
  assign err_code    = code_q;
  assign last_cycles = last_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Drives the conv/maxpool/upsample accelerator TOP through a programmable list of up to NUM_LAYERS layer configurations, replacing hand-fed single-layer config and start pulses.
- Holds a config table; per layer: validates config, presents it on the TOP config bus, pulses start, waits for done with a watchdog timeout, records per-layer cycle count.
- Sits between host/CPU register block and TOP.

Parameters:
- NUM_LAYERS, 8, config table depth (power of two, >=2)
- LIDX_W, 3, layer index width = log2(NUM_LAYERS)
- TMO_W, 24, watchdog and cycle counter width

Ports:
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  synchronous reset, active-high despite name (1 = reset)
- cfg_we  in  1  table write strobe
- cfg_addr  in  LIDX_W  table write index
- cfg_wdata  in  37  packed {ifm_size[8:0], ifm_channel[10:0], kernel_size[1:0], num_filter[10:0], maxpool_mode, maxpool_stride[1:0], upsample_mode}, MSB first
- num_layers  in  LIDX_W+1  layers to run, 1..NUM_LAYERS
- timeout_limit  in  TMO_W  watchdog limit in cycles; 0 disables
- run  in  1  one-cycle launch request
- abort  in  1  stop sequence
- acc_done  in  1  TOP done
- start  out  1  one-cycle start pulse to TOP
- ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode, maxpool_stride, upsample_mode  out  9/11/2/11/1/2/1  config to TOP, registered
- ofm_size  out  9  expected output size of current layer
- layer_idx  out  LIDX_W  current layer
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse, all layers finished
- error  out  1  sticky until next run or reset
- err_code  out  2  1 = invalid config, 2 = timeout, 3 = abort
- last_cycles  out  TMO_W  cycles start-to-done of the last completed layer, saturating

Behaviour:
- Reset: all outputs 0, FSM IDLE; table contents not cleared.
- Table write: cfg_we writes cfg_wdata at cfg_addr next edge; writes while busy are ignored.
- FSM IDLE -> LOAD on run (run with num_layers 0 or > NUM_LAYERS: error, err_code 1, stay IDLE). run clears error/err_code, layer_idx=0.
- LOAD (1 cycle): read entry layer_idx into config outputs; compute ofm_size; validate. Invalid -> ERR. Valid -> START.
- Validity: kernel_size in {1,3}; ifm_size >= kernel_size; ifm_channel != 0; num_filter != 0; not (maxpool_mode && upsample_mode); maxpool_mode implies stride in {1,2}.
- ofm_size: c = ifm_size - kernel_size + 1; upsample ? 2c : maxpool ? (stride==1 ? c : c>>1) : c; 9-bit truncation.
- START: start=1 exactly one cycle; config outputs stable from LOAD until leaving WAIT; -> WAIT, counter cleared.
- WAIT: counter +1 per cycle (saturate all-ones). acc_done -> NEXT, last_cycles <= counter+1. timeout_limit!=0 and counter+1 == timeout_limit without done -> ERR, err_code 2.
- acc_done outside WAIT is ignored. acc_done and timeout in same cycle: done wins.
- NEXT: layer_idx+1 == num_layers -> DONE; else layer_idx+1, -> LOAD.
- DONE: seq_done pulse one cycle, busy=0, -> IDLE; layer_idx holds last layer.
- ERR: error=1, busy=0, -> IDLE; layer_idx holds failing layer.
- abort in LOAD/START/WAIT/NEXT -> ERR err_code 3 next edge; abort has priority over acc_done; ignored in IDLE.
- busy=1 in LOAD, START, WAIT, NEXT.
- run while busy ignored.
- Reset mid-sequence: next edge returns to IDLE, start forced 0, no seq_done.

Test Plan:
- Program 3 layers (13/32/k1/15 no pool; 26/16/k3/32 maxpool stride2; 13/64/k1/8 upsample), num_layers=3, done 50 cycles after each start -> 3 start pulses, ofm_size 13, 12, 26, last_cycles=50, seq_done once, error=0.
- Layer 1 kernel_size=2 -> after layer 0 done, ERR, err_code=1, layer_idx=1, only 1 start issued.
- timeout_limit=100, acc_done never -> error at 100 cycles after start, err_code=2; with done at cycle 100 exactly -> no error.
- abort same cycle as acc_done in WAIT -> err_code=3, no seq_done; next run clears error and restarts at layer 0.
- Reset asserted in WAIT layer 2 -> all outputs 0 next edge; table retained, new run replays identically.
- run with num_layers=0 -> error, err_code=1, no start; cfg_we during busy leaves entry unchanged.
